// File: rtl/cmp_pkg.sv
// Shared definitions for the comparator result checker: FSM states and
// bit positions inside the {great,less,equal} flag vector.
package cmp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int FLAG_W  = 3;
    localparam int FLAG_GT = 2;
    localparam int FLAG_LT = 1;
    localparam int FLAG_EQ = 0;

endpackage

// File: rtl/cmp_ref.sv
// Reference comparator: the flag vector a correct unsigned N-bit comparator
// must return for operands x and y.
module cmp_ref
    import cmp_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]      x,
    input  logic [N-1:0]      y,
    output logic [FLAG_W-1:0] exp_flags
);

    always_comb begin
        exp_flags          = '0;
        exp_flags[FLAG_GT] = (x > y);
        exp_flags[FLAG_LT] = (x < y);
        exp_flags[FLAG_EQ] = (x == y);
    end

endmodule

// File: rtl/cmp_result_checker.sv
// Checks a stream of comparator results against cmp_ref: stage 1 registers
// each accepted beat, stage 2 compares and updates the run statistics.
module cmp_result_checker
    import cmp_pkg::*;
#(
    parameter int N  = 4,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] num_samples,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  x,
    input  logic [N-1:0]  y,
    input  logic          great,
    input  logic          less,
    input  logic          equal,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic          err,
    output logic [CW-1:0] err_count,
    output logic [CW-1:0] sample_count,
    output logic [N-1:0]  first_err_x,
    output logic [N-1:0]  first_err_y,
    output logic [2:0]    first_err_flags
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    state_e              state_q, state_d;
    logic [CW-1:0]       num_q, num_d;
    logic [CW-1:0]       acc_q, acc_d;
    logic                s1_vld_q, s1_vld_d;
    logic [N-1:0]        s1_x_q, s1_x_d;
    logic [N-1:0]        s1_y_q, s1_y_d;
    logic [FLAG_W-1:0]   s1_flags_q, s1_flags_d;
    logic [CW-1:0]       err_count_q, err_count_d;
    logic [CW-1:0]       sample_count_q, sample_count_d;
    logic                err_q, err_d;
    logic [N-1:0]        fe_x_q, fe_x_d;
    logic [N-1:0]        fe_y_q, fe_y_d;
    logic [FLAG_W-1:0]   fe_flags_q, fe_flags_d;

    logic [FLAG_W-1:0]   exp_flags;
    logic                accept;
    logic                mismatch;
    logic                rdy;

    cmp_ref #(.N(N)) u_ref (
        .x         (s1_x_q),
        .y         (s1_y_q),
        .exp_flags (exp_flags)
    );

    always_comb begin
        state_d        = state_q;
        num_d          = num_q;
        acc_d          = acc_q;
        s1_vld_d       = 1'b0;
        s1_x_d         = s1_x_q;
        s1_y_d         = s1_y_q;
        s1_flags_d     = s1_flags_q;
        err_count_d    = err_count_q;
        sample_count_d = sample_count_q;
        err_d          = err_q;
        fe_x_d         = fe_x_q;
        fe_y_d         = fe_y_q;
        fe_flags_d     = fe_flags_q;

        rdy      = (state_q == ST_RUN) && (acc_q < num_q);
        accept   = in_valid && rdy;
        // Any non-one-hot pattern differs from the one-hot expectation, so a
        // plain vector compare also catches illegal flag combinations.
        mismatch = s1_vld_q && (s1_flags_q != exp_flags);

        if (accept) begin
            s1_vld_d   = 1'b1;
            s1_x_d     = x;
            s1_y_d     = y;
            s1_flags_d = {great, less, equal};
        end

        if (s1_vld_q) begin
            if (sample_count_q != CNT_MAX) sample_count_d = sample_count_q + CW'(1);
            if (mismatch) begin
                if (err_count_q != CNT_MAX) err_count_d = err_count_q + CW'(1);
                err_d = 1'b1;
                if (!err_q) begin
                    fe_x_d     = s1_x_q;
                    fe_y_d     = s1_y_q;
                    fe_flags_d = s1_flags_q;
                end
            end
        end

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    num_d          = num_samples;
                    acc_d          = '0;
                    err_count_d    = '0;
                    sample_count_d = '0;
                    err_d          = 1'b0;
                    fe_x_d         = '0;
                    fe_y_d         = '0;
                    fe_flags_d     = '0;
                    state_d        = (num_samples == '0) ? ST_FLUSH : ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    acc_d = acc_q + CW'(1);
                    if ((acc_q + CW'(1)) == num_q) state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // Stage 2 retires the last beat on the edge s1 empties.
                if (!s1_vld_q) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            num_q          <= '0;
            acc_q          <= '0;
            s1_vld_q       <= 1'b0;
            s1_x_q         <= '0;
            s1_y_q         <= '0;
            s1_flags_q     <= '0;
            err_count_q    <= '0;
            sample_count_q <= '0;
            err_q          <= 1'b0;
            fe_x_q         <= '0;
            fe_y_q         <= '0;
            fe_flags_q     <= '0;
        end else begin
            state_q        <= state_d;
            num_q          <= num_d;
            acc_q          <= acc_d;
            s1_vld_q       <= s1_vld_d;
            s1_x_q         <= s1_x_d;
            s1_y_q         <= s1_y_d;
            s1_flags_q     <= s1_flags_d;
            err_count_q    <= err_count_d;
            sample_count_q <= sample_count_d;
            err_q          <= err_d;
            fe_x_q         <= fe_x_d;
            fe_y_q         <= fe_y_d;
            fe_flags_q     <= fe_flags_d;
        end
    end

    assign in_ready        = rdy;
    assign busy            = (state_q == ST_RUN) || (state_q == ST_FLUSH);
    assign done            = (state_q == ST_DONE);
    assign pass            = done && (err_count_q == '0);
    assign err             = err_q;
    assign err_count       = err_count_q;
    assign sample_count    = sample_count_q;
    assign first_err_x     = fe_x_q;
    assign first_err_y     = fe_y_q;
    assign first_err_flags = fe_flags_q;

endmodule

// File: tb/tb_cmp_result_checker.sv
// Directed bench for cmp_result_checker with hand-computed expectations.
module tb_cmp_result_checker;

    localparam int N  = 4;
    localparam int CW = 16;

    logic          clk;
    logic          rst;
    logic          start;
    logic [CW-1:0] num_samples;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  x, y;
    logic          great, less, equal;
    logic          busy, done, pass, err;
    logic [CW-1:0] err_count, sample_count;
    logic [N-1:0]  first_err_x, first_err_y;
    logic [2:0]    first_err_flags;

    int checks = 0;
    int errors = 0;
    int acc_n  = 0;

    cmp_result_checker #(.N(N), .CW(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .num_samples     (num_samples),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .x               (x),
        .y               (y),
        .great           (great),
        .less            (less),
        .equal           (equal),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err             (err),
        .err_count       (err_count),
        .sample_count    (sample_count),
        .first_err_x     (first_err_x),
        .first_err_y     (first_err_y),
        .first_err_flags (first_err_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the run has started.
    task automatic start_run(input logic [CW-1:0] n);
        start       = 1'b1;
        num_samples = n;
        @(posedge clk); #1;
        start = 1'b0;
        acc_n = 0;
    endtask

    // Presents one beat and holds it until accepted; in_valid stays high.
    task automatic beat(input logic [3:0] bx, input logic [3:0] by, input logic [2:0] bf);
        logic rdy;
        bit   ok;
        ok = 1'b0;
        x = bx; y = by; {great, less, equal} = bf; in_valid = 1'b1;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk); rdy = in_ready;
            @(posedge clk); #1;
            if (rdy) begin acc_n++; ok = 1'b1; end
        end
        if (!ok) chk("beat_accept", 32'(0), 32'(1));
    endtask

    task automatic wait_done;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk); ok = done;
        end
        chk("done", 32'(done), 32'(1));
        @(posedge clk); #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_flags"}, 32'({busy, done, pass, err, in_ready, first_err_flags,
                                 first_err_x, first_err_y}), 32'(0));
        chk({tag, "_cnts"}, 32'({err_count, sample_count}), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; num_samples = '0; in_valid = 1'b0;
        x = '0; y = '0; great = 1'b0; less = 1'b0; equal = 1'b0;
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        check_idle("reset");

        // Correct run; a start pulse mid-run must be ignored.
        start_run(16'd4);
        chk("run_busy", 32'({busy, in_ready}), 32'(3));
        beat(4'b1101, 4'b1101, 3'b001);
        start = 1'b1; num_samples = 16'd9;
        beat(4'b1110, 4'b1100, 3'b100);
        start = 1'b0;
        beat(4'b0101, 4'b0111, 3'b010);
        beat(4'b1010, 4'b1010, 3'b001);
        in_valid = 1'b0;
        wait_done();
        chk("a_pass", 32'({pass, err, busy}), 32'(4));
        chk("a_errcnt", 32'(err_count), 32'(0));
        chk("a_samples", 32'(sample_count), 32'(4));
        repeat (3) @(posedge clk); #1;
        chk("a_hold", 32'({done, pass, sample_count}), 32'({1'b1, 1'b1, 16'd4}));

        // Wrong flag, then illegal flag, then correct beat.
        start_run(16'd3);
        beat(4'b1011, 4'b0011, 3'b001);
        in_valid = 1'b0;
        chk("b_err_lat1", 32'(err), 32'(0));
        @(posedge clk); #1;
        chk("b_err_lat2", 32'({err, err_count}), 32'({1'b1, 16'd1}));
        chk("b_samp_lat2", 32'(sample_count), 32'(1));
        beat(4'b0111, 4'b0111, 3'b011);
        beat(4'b0001, 4'b0010, 3'b010);
        in_valid = 1'b0;
        wait_done();
        chk("b_errcnt", 32'(err_count), 32'(2));
        chk("b_samples", 32'(sample_count), 32'(3));
        chk("b_pass", 32'(pass), 32'(0));
        chk("b_first", 32'({first_err_x, first_err_y, first_err_flags}),
            32'({4'b1011, 4'b0011, 3'b001}));

        // Illegal pattern alone.
        start_run(16'd1);
        beat(4'b0111, 4'b0111, 3'b011);
        in_valid = 1'b0;
        wait_done();
        chk("c_errcnt", 32'({err, err_count}), 32'({1'b1, 16'd1}));
        chk("c_first", 32'({first_err_x, first_err_y, first_err_flags}),
            32'({4'b0111, 4'b0111, 3'b011}));

        // Backpressure at the run boundary.
        start_run(16'd2);
        for (int i = 0; i < 5; i++) begin
            x = 4'b0011; y = 4'b0011; {great, less, equal} = 3'b001; in_valid = 1'b1;
            @(negedge clk); if (in_ready) acc_n++;
            @(posedge clk); #1;
        end
        chk("d_ready_low", 32'(in_ready), 32'(0));
        in_valid = 1'b0;
        chk("d_accepted", 32'(acc_n), 32'(2));
        wait_done();
        chk("d_samples", 32'({pass, sample_count}), 32'({1'b1, 16'd2}));

        // Zero-length run with in_valid held high throughout.
        in_valid = 1'b1;
        start_run(16'd0);
        chk("e_ready", 32'({busy, in_ready}), 32'(2));
        wait_done();
        in_valid = 1'b0;
        chk("e_result", 32'({pass, err_count, sample_count}), 32'({1'b1, 16'd0, 16'd0}));

        // Reset mid-run (with start asserted too), then a clean short run.
        start_run(16'd4);
        beat(4'b0010, 4'b0001, 3'b100);
        beat(4'b0010, 4'b0001, 3'b001);
        in_valid = 1'b0;
        rst = 1'b1; start = 1'b1; num_samples = 16'd3;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        check_idle("midrst");
        repeat (3) @(posedge clk); #1;
        check_idle("midrst_settle");
        start_run(16'd2);
        beat(4'b0000, 4'b0000, 3'b001);
        beat(4'b1111, 4'b0000, 3'b100);
        in_valid = 1'b0;
        wait_done();
        chk("f_result", 32'({pass, err, sample_count}), 32'({1'b1, 1'b0, 16'd2}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmp_result_checker.md
CMP_RESULT_CHECKER -- requirements
Module: cmp_result_checker

Interface
REQ-001 SHALL have parameter N, default 4, giving the operand width in bits.
REQ-002 SHALL have parameter CW, default 16, giving the width of all counters.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: pulse that begins a checking run.
REQ-006 SHALL have port num_samples, input, CW bits: beats per run, sampled when start is accepted.
REQ-007 SHALL have port in_valid, input, 1 bit: the beat on x, y and the flags is valid.
REQ-008 SHALL have port in_ready, output, 1 bit: the checker accepts a beat this cycle.
REQ-009 SHALL have ports x and y, input, N bits each: the operands presented to the comparator under test.
REQ-010 SHALL have ports great, less and equal, input, 1 bit each: the flags returned by the comparator under test.
REQ-011 SHALL have port busy, output, 1 bit: high while in RUN or FLUSH.
REQ-012 SHALL have port done, output, 1 bit: high while in DONE.
REQ-013 SHALL have port pass, output, 1 bit: high in DONE when err_count equals 0.
REQ-014 SHALL have port err, output, 1 bit: sticky mismatch flag for the current run.
REQ-015 SHALL have ports err_count and sample_count, output, CW bits each.
REQ-016 SHALL have ports first_err_x and first_err_y, output, N bits each, and first_err_flags, output, 3 bits ordered {great,less,equal}.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, FLUSH and DONE.
REQ-018 SHALL move from IDLE to RUN on start, capture num_samples, and clear all counters, err and first_err_* in the same edge.
REQ-019 SHALL drive in_ready high only in RUN while accepted beats are fewer than the captured num_samples.
REQ-020 SHALL treat a beat as accepted only when in_valid and in_ready are both high in the same cycle; beats with in_valid high and in_ready low are ignored.
REQ-021 SHALL move from RUN to FLUSH in the cycle after the last beat is accepted.
REQ-022 SHALL move from IDLE straight to FLUSH when start is accepted with num_samples equal to 0; that run SHALL finish with pass high and sample_count equal to 0.
REQ-023 SHALL stay in FLUSH until its 2-stage pipeline is empty, then move to DONE.
REQ-024 SHALL restart from DONE on start exactly as from IDLE, and SHALL ignore start in RUN and FLUSH.
REQ-025 SHALL use pipeline stage 1 to register each accepted beat's x, y and flags.
REQ-026 SHALL use pipeline stage 2 to form the expected flags from unsigned x>y, x<y and x==y and compare them with the registered flags.
REQ-027 SHALL update sample_count, err_count and err 2 cycles after the beat is accepted.
REQ-028 SHALL count a beat as a mismatch when the received flags differ from the expected flags, which includes any received flag pattern that is not one-hot.
REQ-029 SHALL, on the first mismatch of a run only, load first_err_x, first_err_y and first_err_flags from that beat.
REQ-030 SHALL saturate err_count and sample_count at 2^CW-1.
REQ-031 SHALL accept one beat per cycle at full throughput with no bubbles.
REQ-032 SHALL hold all outputs stable in DONE until the next start or rst.

Reset
REQ-033 SHALL, when rst is high at a clock edge, enter IDLE and clear the pipeline, all counters, err, pass, done, busy, in_ready and first_err_* to 0.
REQ-034 SHALL, on rst mid-run, discard any beats in flight without counting them.
REQ-035 SHALL give rst priority over start when both are high in the same cycle.

Structure
REQ-036 SHALL place the FSM state encoding and the flag-vector bit positions (great=2, less=1, equal=0) in a shared package, cmp_pkg.
REQ-037 SHALL place the expected-flag computation in one sub-module, cmp_ref, which is purely combinational and parameterised by N.

Verification
REQ-038 SHALL cover a correct run: num_samples=4, beats (1101,1101,001), (1110,1100,100), (0101,0111,010), (1010,1010,001) -> done high, pass high, err_count=0, sample_count=4.
REQ-039 SHALL cover a wrong flag: beat (1011,0011) with flags 001 -> err high 2 cycles after acceptance, err_count=1, first_err_x=1011, first_err_y=0011, first_err_flags=001.
REQ-040 SHALL cover an illegal flag pattern: beat (0111,0111) with flags 011 -> counted as a mismatch, first_err_flags=011.
REQ-041 SHALL cover backpressure at the run boundary: num_samples=2 with in_valid held high for 5 cycles -> in_ready low after 2 accepted beats, sample_count=2.
REQ-042 SHALL cover num_samples=0 -> done high with no beat accepted, pass high.
REQ-043 SHALL cover rst mid-run: rst asserted after 2 of 4 beats -> IDLE, all outputs 0; a following run of 2 correct beats ends with pass high and sample_count=2.
